// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM encodings and default sizing for the debounce input stage
package debounce_pkg;

  localparam logic [1:0] S_LOW       = 2'd0;
  localparam logic [1:0] S_WAIT_HIGH = 2'd1;
  localparam logic [1:0] S_HIGH      = 2'd2;
  localparam logic [1:0] S_WAIT_LOW  = 2'd3;

  localparam int DEFAULT_SYNC_STAGES     = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - parameterised multi-flop synchroniser, async reset to 0
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronise and debounce a raw level; edge pulses under DEBOUNCE_SYNC_EDGE_EN
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync;
  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dout_q, dout_d;
  logic                 busy_q, busy_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
    end
  end

  // Counter saturates at CNT_MAX by construction: reaching it always leaves the WAIT state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOW: begin
        if (sync) begin
          state_d = S_WAIT_HIGH;
          cnt_d   = '0;
        end
      end
      S_WAIT_HIGH: begin
        if (!sync) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_HIGH: begin
        if (!sync) begin
          state_d = S_WAIT_LOW;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOW: begin
        if (sync) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // The accepted level is high in S_HIGH and while a fall is still being qualified.
  always_comb begin
    dout_d = (state_d == S_HIGH) || (state_d == S_WAIT_LOW);
    busy_d = (state_d == S_WAIT_HIGH) || (state_d == S_WAIT_LOW);
  end

  assign dout = dout_q;
  assign busy = busy_q;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    rise_d = (state_q == S_WAIT_HIGH) && (state_d == S_HIGH);
    fall_d = (state_q == S_WAIT_LOW) && (state_d == S_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
`else
  assign rise_pulse = 1'b0;
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - scoreboard bench for debounce_sync (DEBOUNCE_CYCLES=4 and =1)
module tb_debounce_sync;

`ifdef DEBOUNCE_SYNC_EDGE_EN
  localparam logic EDGE_EN = 1'b1;
`else
  localparam logic EDGE_EN = 1'b0;
`endif

  typedef struct {
    int   at_cyc;
    logic dout;
    logic rise;
    logic fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout, rise_pulse, fall_pulse, busy;
  logic din_b = 1'b0;
  logic dout_b, rise_b, fall_b, busy_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_dout = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .din(din), .dout(dout),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .busy(busy)
  );

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(4)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .dout(dout_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b), .busy(busy_b)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  // Called at a negedge right after din changes: the next edge samples it.
  task automatic expect_change(input logic lvl);
    exp_t e;
    e.at_cyc = cyc + 1 + 6;
    e.dout   = lvl;
    e.rise   = EDGE_EN & lvl;
    e.fall   = EDGE_EN & ~lvl;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if (dout !== prev_dout) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_dout_change cyc=%0d actual=%b required=%b", cyc, dout, prev_dout);
        end else begin
          e = exp_q.pop_front();
          if (cyc != e.at_cyc || dout !== e.dout || rise_pulse !== e.rise || fall_pulse !== e.fall) begin
            errors++;
            $display("FAIL dout_event actual cyc=%0d dout=%b rise=%b fall=%b required cyc=%0d dout=%b rise=%b fall=%b",
                     cyc, dout, rise_pulse, fall_pulse, e.at_cyc, e.dout, e.rise, e.fall);
          end
        end
      end else if (rise_pulse || fall_pulse) begin
        errors++;
        $display("FAIL spurious_pulse cyc=%0d actual rise=%b fall=%b required 0 0", cyc, rise_pulse, fall_pulse);
      end
      checks++;
      if (u_b.cnt_q !== 4'd0) begin
        errors++;
        $display("FAIL b_counter cyc=%0d actual=%0d required=0", cyc, u_b.cnt_q);
      end
    end
    prev_dout = dout;
  end

  initial begin
    @(negedge rst);
    step(3);
    din_b = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      step(1);
      if (k == 1) check("b_rise_busy_k1", busy_b, 1'b0);
      if (k == 2) begin check("b_rise_busy_k2", busy_b, 1'b1); check("b_rise_dout_k2", dout_b, 1'b0); end
      if (k == 3) begin
        check("b_rise_dout_k3", dout_b, 1'b1);
        check("b_rise_pulse_k3", rise_b, EDGE_EN);
        check("b_rise_busy_k3", busy_b, 1'b0);
      end
      if (k == 4) check("b_rise_pulse_k4", rise_b, 1'b0);
    end
    din_b = 1'b0;
    for (int k = 0; k <= 3; k++) begin
      step(1);
      if (k == 2) check("b_fall_dout_k2", dout_b, 1'b1);
      if (k == 3) begin check("b_fall_dout_k3", dout_b, 1'b0); check("b_fall_pulse_k3", fall_b, EDGE_EN); end
    end
  end

  initial begin
    step(2);
    check("rst_dout", dout, 1'b0);
    check("rst_rise", rise_pulse, 1'b0);
    check("rst_fall", fall_pulse, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step(3);

    // clean rise with busy window, then clean fall
    din = 1'b1;
    expect_change(1'b1);
    for (int k = 0; k <= 6; k++) begin
      step(1);
      check("rise_busy_window", busy, (k >= 2 && k <= 5));
    end
    step(3);
    din = 1'b0;
    expect_change(1'b0);
    step(10);

    // bounce: only the final held level is accepted
    din = 1'b1; step(2);
    din = 1'b0; step(2);
    din = 1'b1; step(2);
    din = 1'b0; step(2);
    din = 1'b1;
    expect_change(1'b1);
    step(10);
    din = 1'b0;
    expect_change(1'b0);
    step(10);

    // short glitch
    din = 1'b1;
    step(3);
    check("glitch_busy_mid", busy, 1'b1);
    din = 1'b0;
    step(8);
    check("glitch_busy_end", busy, 1'b0);
    check("glitch_dout", dout, 1'b0);

    // async reset during fall qualification, then din high across release
    din = 1'b1;
    expect_change(1'b1);
    step(10);
    din = 1'b0;
    step(4);
    check("pre_rst_busy", busy, 1'b1);
    check("pre_rst_dout", dout, 1'b1);
    #2;
    din = 1'b1;
    rst = 1'b1;
    #1;
    check("async_rst_dout", dout, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_rise", rise_pulse, 1'b0);
    check("async_rst_fall", fall_pulse, 1'b0);
    step(2);
    rst = 1'b0;
    expect_change(1'b1);
    step(10);
    din = 1'b0;
    expect_change(1'b0);
    step(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input conditioning stage that sits directly upstream of the design's flip-flop and register stages. It takes a raw asynchronous level, such as a push-button, switch or external strobe, and synchronises it into the clk domain. It then debounces the level with a stability counter and delivers a clean registered level plus one-cycle edge pulses. Downstream D flip-flops and counters consume dout, rise_pulse and fall_pulse as ordinary synchronous inputs.

## Interface
- Parameters:
  - SYNC_STAGES, default 2: number of synchroniser flops; legal range is 2 or more.
  - DEBOUNCE_CYCLES, default 50000: consecutive stable synced cycles required to accept a new level; legal range is 1 or more.
  - CNT_WIDTH, default 16: stability counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.
- Ports:
  - clk, in, 1: clock; all state updates on its rising edge.
  - rst, in, 1: reset, asynchronous, active-high.
  - din, in, 1: raw asynchronous input level.
  - dout, out, 1: debounced, registered level.
  - rise_pulse, out, 1: one-cycle pulse when dout goes 0 to 1.
  - fall_pulse, out, 1: one-cycle pulse when dout goes 1 to 0.
  - busy, out, 1: high while a candidate change is being qualified.

## Operation
- **Synchroniser:** din passes through SYNC_STAGES flops. The output of the last flop is called sync.
- **FSM states:** S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW. Reset state is S_LOW.
- **Leaving a stable state:**
  - In S_LOW, sync=1 moves the FSM to S_WAIT_HIGH and clears the counter to 0.
  - In S_HIGH, sync=0 moves the FSM to S_WAIT_LOW and clears the counter to 0.
- **Qualifying a change:**
  - In S_WAIT_HIGH, sync=1 with counter < DEBOUNCE_CYCLES-1 increments the counter.
  - In S_WAIT_HIGH, sync=1 with counter == DEBOUNCE_CYCLES-1 moves the FSM to S_HIGH, sets dout to 1 and asserts rise_pulse for that one cycle.
  - S_WAIT_LOW behaves the same way with the polarity reversed: it moves to S_LOW, sets dout to 0 and asserts fall_pulse.
- **Bounce:** in S_WAIT_HIGH, sync=0 returns the FSM to S_LOW and clears the counter; dout is unchanged and no pulse is produced. The reversed case applies in S_WAIT_LOW.
- **busy:** equals 1 exactly when the FSM is in a WAIT state; it is registered with the state.
- **Counter range:** the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- **DEBOUNCE_CYCLES=1:** the WAIT state lasts exactly one cycle. The change is accepted on the first WAIT-state edge where sync still matches the candidate.
- **Pulses:** rise_pulse and fall_pulse are never high together. Neither is ever high for two consecutive cycles.

## Timing
- **Reset values:** dout=0, rise_pulse=0, fall_pulse=0, busy=0, counter=0, all synchroniser flops 0.
- **Reset assertion:** asynchronous; takes effect immediately, including mid-qualification.
- **Reset release:** the FSM resumes sampling on the first clk edge after rst deasserts.
- **din high at reset release:** this is qualified as a normal rise. rise_pulse fires after full latency.
- **Latency:** from the first clk edge that samples a new din level held steady, dout and the pulse change exactly SYNC_STAGES + DEBOUNCE_CYCLES edges later.
- **Pulse alignment:** a pulse is high in the same cycle that dout first shows the new level.
- **Minimum accepted pulse width:** a din level held for fewer than DEBOUNCE_CYCLES synced cycles is discarded.
- **Back-to-back changes:** a change arriving the cycle after acceptance starts a fresh qualification. No dead time is inserted.

## Configuration
- Macro: DEBOUNCE_SYNC_EDGE_EN.
- **Defined:** rise_pulse and fall_pulse are generated as described above.
- **Undefined:**
  - The edge logic is compiled out.
  - rise_pulse and fall_pulse are tied to 0.
  - dout, busy and latency are unchanged.
  - The ports remain present.

## Structure
- Shared package debounce_pkg holds:
  - the FSM state encodings S_LOW, S_WAIT_HIGH, S_HIGH, S_WAIT_LOW as 2-bit constants;
  - the default DEBOUNCE_CYCLES and SYNC_STAGES values.
- One sub-module, sync_chain:
  - parameterised SYNC_STAGES flop chain;
  - async reset to 0;
  - reused by other input stages.
- The FSM, counter and edge logic live in debounce_sync.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 unless noted.
- **Reset:** assert rst with din=1 mid-run -> all outputs 0 immediately. Release with din=1 held -> dout=1 and a single rise_pulse exactly 6 edges later.
- **Clean rise then fall:** din 0->1 held 10 cycles -> dout=1 and rise_pulse at edge 6, busy high for the 4 preceding cycles. Then din->0 held -> dout=0 and fall_pulse 6 edges later.
- **Bounce:** din toggled 1,0,1,0 every 2 cycles, then held 1 -> no dout change during toggling. A single rise_pulse arrives 6 edges after the final 0->1.
- **Short glitch:** din=1 for 3 cycles then 0 -> dout stays 0, no pulses, busy returns to 0.
- **Boundary:** DEBOUNCE_CYCLES=1, din 0->1 -> dout=1 after 3 edges. The counter never exceeds 0.
- **Macro off:** DEBOUNCE_SYNC_EDGE_EN undefined, rerun the clean rise/fall scenario -> dout timing identical, rise_pulse and fall_pulse constant 0.
